trace_recorder: RTL and testbench

Synthesizable, parametrised successor to the nic8 simulation monitor. It samples CHANNELS architectural registers (pc, ir, areg, breg, xreg, qreg by default) every clock. It records time-stamped snapshots into an on-chip FIFO, either every cycle or only on change, with a per-channel change mask and a capture limit. A host (UART dumper or testbench) drains the FIFO through a valid/ready port, so traces survive on hardware where `$display` does not exist.

---
 rtl/trace_pkg.sv | 19 +
 rtl/trace_recorder_if.sv | 23 ++
 rtl/trace_fifo.sv | 54 +++++
 rtl/trace_recorder.sv | 135 +++++++++++++
 tb/tb_trace_recorder.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// trace_recorder shared types.
// Capture FSM states and the FIFO entry width helper.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic int entry_bits(
    input int tickw,
    input int ch,
    input int w
  );
    return tickw + ch + ch * w;
  endfunction

endpackage

// File: rtl/trace_recorder_if.sv
// Drain port of the trace recorder.
// master = recorder side, slave = host side.
interface trace_recorder_if #(
  parameter int EW = 70
);

  logic [EW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;

  modport master (
    output rd_data,
    output rd_valid,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_valid,
    output rd_ready
  );

endinterface

// File: rtl/trace_fifo.sv
// Show-ahead FIFO for trace entries.
// Flush beats push and pop; push on full is accepted only with a pop.
module trace_fifo #(
  parameter int WIDTH_E = 70,
  parameter int DEPTH   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [WIDTH_E-1:0] data_i,
  output logic [WIDTH_E-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH_E-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wptr_q;
  logic [AW-1:0]      rptr_q;
  logic [CW-1:0]      cnt_q;
  logic               do_push;
  logic               do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/trace_recorder.sv
// Time-stamped register trace recorder with FIFO drain port.
// Holds the capture FSM, counters, prev snapshot and change mask.
module trace_recorder
  import trace_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 6,
  parameter int DEPTH    = 16,
  parameter int TICKW    = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS*WIDTH-1:0] ch_data,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      change_only,
  input  logic [TICKW-1:0]          limit,
  input  logic                      flush,
  trace_recorder_if.master          rd,
  output logic                      running,
  output logic                      overflow,
  output logic [TICKW-1:0]          drop_count
);

  localparam int EW = entry_bits(TICKW, CHANNELS, WIDTH);

  state_e                    state_q;
  logic                      running_q;
  logic [TICKW-1:0]          tick_q;
  logic [TICKW-1:0]          cnt_q;
  logic [TICKW-1:0]          cnt_d;
  logic [CHANNELS*WIDTH-1:0] prev_q;
  logic                      prev_vld_q;
  logic                      ovf_q;
  logic [TICKW-1:0]          drop_q;

  logic [CHANNELS-1:0] mask;
  logic                cap;
  logic                lim_hit;
  logic                pop;
  logic                full;
  logic                empty;
  logic                drop;
  logic [EW-1:0]       entry;

  always_comb begin
    mask = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      mask[k] = !prev_vld_q ||
        (ch_data[k*WIDTH +: WIDTH] != prev_q[k*WIDTH +: WIDTH]);
    end
  end

  assign cap     = (state_q == RUN) &&
                   (!change_only || (mask != '0));
  assign cnt_d   = cnt_q + TICKW'(1);
  assign lim_hit = cap && (limit != '0) && (cnt_d == limit);
  assign entry   = {tick_q, mask, ch_data};
  assign pop     = rd.rd_valid && rd.rd_ready;
  // A pop frees the slot the same edge, so only a stalled full FIFO drops.
  assign drop    = cap && full && !pop && !flush;

  assign rd.rd_valid = !empty;
  assign running     = running_q;
  assign overflow    = ovf_q;
  assign drop_count  = drop_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      running_q  <= 1'b0;
      tick_q     <= '0;
      cnt_q      <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start && stop) begin
            state_q <= DONE;
          end else if (start) begin
            state_q    <= RUN;
            running_q  <= 1'b1;
            tick_q     <= '0;
            cnt_q      <= '0;
            prev_vld_q <= 1'b0;
          end
        end
        RUN: begin
          tick_q     <= tick_q + TICKW'(1);
          prev_q     <= ch_data;
          prev_vld_q <= 1'b1;
          if (cap) cnt_q <= cnt_d;
          if (stop || lim_hit) begin
            state_q   <= DONE;
            running_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (flush) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (drop_q != '1) drop_q <= drop_q + TICKW'(1);
    end
  end

  trace_fifo #(
    .WIDTH_E (EW),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (cap),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (entry),
    .data_o  (rd.rd_data),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_trace_recorder.sv
// Bench for trace_recorder: queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_trace_recorder;
  import trace_pkg::*;

  localparam int EW = entry_bits(16, 6, 8);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [47:0]   ch = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          change_only = 1'b0;
  logic [15:0]   limit = '0;
  logic          flush = 1'b0;
  logic          rd_ready = 1'b0;
  logic          running;
  logic          overflow;
  logic [15:0]   drop_count;
  logic [EW-1:0] rd_data;
  logic          rd_valid;

  int checks = 0;
  int failures = 0;

  trace_recorder_if #(.EW(EW)) rif ();
  assign rif.rd_ready = rd_ready;
  assign rd_data      = rif.rd_data;
  assign rd_valid     = rif.rd_valid;

  trace_recorder #(
    .WIDTH    (8),
    .CHANNELS (6),
    .DEPTH    (16),
    .TICKW    (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ch_data     (ch),
    .start       (start),
    .stop        (stop),
    .change_only (change_only),
    .limit       (limit),
    .flush       (flush),
    .rd          (rif),
    .running     (running),
    .overflow    (overflow),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [EW-1:0] act,
                     input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference model: a plain queue plus spec-level counters.
  bit            m_run = 0;
  int            m_tick = 0;
  int            m_cnt = 0;
  logic [47:0]   m_prev = '0;
  bit            m_pv = 0;
  bit            m_ovf = 0;
  int            m_drop = 0;
  logic [EW-1:0] m_q[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_run = 0; m_tick = 0; m_cnt = 0;
      m_pv = 0; m_ovf = 0; m_drop = 0;
    end else begin
      bit pop;
      bit cap;
      logic [5:0] mask;
      pop = (m_q.size() != 0) && rd_ready;
      cap = 0;
      mask = '0;
      if (m_run) begin
        for (int k = 0; k < 6; k++)
          mask[k] = !m_pv || (ch[k*8 +: 8] != m_prev[k*8 +: 8]);
        cap = !change_only || (mask != 0);
      end
      if (flush) begin
        m_q.delete();
        m_ovf = 0;
        m_drop = 0;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (cap) begin
          if (m_q.size() < 16) m_q.push_back({16'(m_tick), mask, ch});
          else begin
            m_ovf = 1;
            if (m_drop < 65535) m_drop++;
          end
        end
      end
      if (m_run) begin
        if (cap) m_cnt++;
        m_prev = ch;
        m_pv = 1;
        m_tick = (m_tick + 1) % 65536;
        if (stop || (cap && limit != 0 && (m_cnt % 65536) == limit))
          m_run = 0;
      end else if (start && !stop) begin
        m_run = 1; m_tick = 0; m_cnt = 0; m_pv = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("valid", rd_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("head", rd_data, m_q[0]);
      chk("running", running, m_run);
      chk("overflow", overflow, m_ovf);
      chk("drop", drop_count, 16'(m_drop));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pop_exp(input string nm, input logic [15:0] t,
                         input logic [5:0] m, input logic [47:0] d);
    chk({nm, "_valid"}, rd_valid, 1);
    chk(nm, rd_data, {t, m, d});
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
  endtask

  initial begin
    step(); step();
    chk("rst_valid", rd_valid, 0);
    chk("rst_running", running, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_data", rd_data, 0);
    reset_n = 1'b1;
    step();

    // every-cycle capture with limit 4
    change_only = 0; limit = 16'd4;
    start = 1; step(); start = 0;
    ch = 48'h10; step();
    ch = 48'h11; step();
    ch = 48'h12; step();
    ch = 48'h13; step();
    chk("lim_running", running, 0);
    pop_exp("t1e0", 16'd0, 6'h3f, 48'h10);
    pop_exp("t1e1", 16'd1, 6'h01, 48'h11);
    pop_exp("t1e2", 16'd2, 6'h01, 48'h12);
    pop_exp("t1e3", 16'd3, 6'h01, 48'h13);
    chk("t1_empty", rd_valid, 0);

    // change-only capture
    change_only = 1; limit = 16'd0;
    ch = 48'h645342003120;
    start = 1; step(); start = 0;
    repeat (5) step();
    ch[23:16] = 8'h7f; step();
    stop = 1; step(); stop = 0;
    pop_exp("t2e0", 16'd0, 6'h3f, 48'h645342003120);
    pop_exp("t2e1", 16'd5, 6'h04, 48'h6453427f3120);
    chk("t2_empty", rd_valid, 0);

    // overflow: 20 captures into 16 slots
    flush = 1; step(); flush = 0;
    change_only = 0; limit = 16'd20; ch = '0;
    start = 1; step(); start = 0;
    for (int i = 0; i < 20; i++) begin
      ch = 48'(i); step();
    end
    chk("t3_ovf", overflow, 1);
    chk("t3_drop", drop_count, 4);
    chk("t3_running", running, 0);

    // full FIFO, pop and capture on the same edge
    limit = 16'd1;
    start = 1; step(); start = 0;
    rd_ready = 1; ch = 48'hAA; step(); rd_ready = 0;
    chk("t4_drop", drop_count, 4);
    for (int i = 1; i < 16; i++)
      pop_exp("t4e", 16'(i), 6'h01, 48'(i));
    pop_exp("t4last", 16'd0, 6'h3f, 48'hAA);
    chk("t4_empty", rd_valid, 0);

    // async reset mid-run
    limit = 16'd0;
    start = 1; step(); start = 0;
    step(); step(); step();
    chk("t5_pre_valid", rd_valid, 1);
    reset_n = 0; #1;
    chk("t5_valid", rd_valid, 0);
    chk("t5_running", running, 0);
    chk("t5_drop", drop_count, 0);
    chk("t5_ovf", overflow, 0);
    reset_n = 1;
    step();
    start = 1; step(); start = 0;
    ch = 48'h55; step();
    stop = 1; step(); stop = 0;
    pop_exp("t5e0", 16'd0, 6'h3f, 48'h55);
    pop_exp("t5e1", 16'd1, 6'h00, 48'h55);
    chk("t5_empty", rd_valid, 0);

    // start+stop together, then flush with 5 queued
    start = 1; stop = 1; step(); start = 0; stop = 0;
    chk("t6_running", running, 0);
    step();
    chk("t6_nocap", rd_valid, 0);
    start = 1; step(); start = 0;
    repeat (4) step();
    stop = 1; step(); stop = 0;
    chk("t6_queued", rd_valid, 1);
    flush = 1; step(); flush = 0;
    chk("t6_flushed", rd_valid, 0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
